// File: rtl/li_pkg.sv
// rtl/li_pkg.sv - shared FSM encoding and width helpers for the li_wta winner-take-all block
package li_pkg;

    // Decision FSM: idle, one compare-tree level per cycle, threshold compare.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DECIDE = 2'd2
    } li_state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int li_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Winner index width for an N-entry layer (never below one bit).
    function automatic int li_idxw(input int n);
        return (li_clog2(n) < 1) ? 1 : li_clog2(n);
    endfunction

    // A tree entry is {valid, value, index}; these give its packed width and field offsets.
    function automatic int li_entry_w(input int w, input int idxw);
        return 1 + w + idxw;
    endfunction

    function automatic int li_value_lsb(input int idxw);
        return idxw;
    endfunction

    function automatic int li_valid_bit(input int w, input int idxw);
        return w + idxw;
    endfunction

endpackage

// File: rtl/li_cmp_node.sv
// rtl/li_cmp_node.sv - one compare-tree node choosing between two {valid,value,index} entries
module li_cmp_node #(
    parameter int W    = 24,
    parameter int IDXW = 4
) (
    input  logic            a_valid,
    input  logic [W-1:0]    a_value,
    input  logic [IDXW-1:0] a_index,
    input  logic            b_valid,
    input  logic [W-1:0]    b_value,
    input  logic [IDXW-1:0] b_index,
    output logic            y_valid,
    output logic [W-1:0]    y_value,
    output logic [IDXW-1:0] y_index
);

    logic a_wins;

    // A valid entry beats an invalid one; larger value wins; ties go to the lower index.
    always_comb begin
        a_wins = 1'b0;
        if (a_valid) begin
            if (!b_valid) begin
                a_wins = 1'b1;
            end else if (a_value > b_value) begin
                a_wins = 1'b1;
            end else if ((a_value == b_value) && (a_index <= b_index)) begin
                a_wins = 1'b1;
            end
        end
        y_valid = a_wins ? a_valid : b_valid;
        y_value = a_wins ? a_value : b_value;
        y_index = a_wins ? a_index : b_index;
    end

endmodule

// File: rtl/li_wta.sv
// rtl/li_wta.sv - lateral-inhibition winner-take-all with sequential compare tree (optional LI_REFRACTORY_EN)
module li_wta
    import li_pkg::*;
#(
    parameter  int N      = 16,
    parameter  int W      = 24,
    parameter  int REFRAC = 4,
    localparam int IDXW   = li_idxw(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_li,
    input  logic [N*W-1:0]  potentials,
    input  logic [W-1:0]    threshold,
    input  logic            clear_first,
    output logic            busy,
    output logic            valid_li,
    output logic [N-1:0]    won_lost,
    output logic [IDXW-1:0] winner_idx,
    output logic            spiked,
    output logic            first_spike
);

    localparam int S    = li_clog2(N);
    localparam int P    = 1 << S;
    localparam int H    = P / 2;
    localparam int LVLW = li_clog2(S + 1);
    localparam logic [N-1:0] ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

    li_state_e       state_q, state_d;
    logic [LVLW-1:0] lvl_q, lvl_d;
    logic [W-1:0]    thr_q, thr_d;

    logic            vld_q [P];
    logic            vld_d [P];
    logic [W-1:0]    val_q [P];
    logic [W-1:0]    val_d [P];
    logic [IDXW-1:0] idx_q [P];
    logic [IDXW-1:0] idx_d [P];

    logic            nxt_vld [H];
    logic [W-1:0]    nxt_val [H];
    logic [IDXW-1:0] nxt_idx [H];

    logic            valid_q, valid_d;
    logic [N-1:0]    won_q, won_d;
    logic [IDXW-1:0] widx_q, widx_d;
    logic            spiked_q, spiked_d;
    logic            first_q, first_d;
    logic            armed_q, armed_d;
    logic            root_spk;

`ifdef LI_REFRACTORY_EN
    localparam int CNTW = li_clog2(REFRAC + 1);
    logic [CNTW-1:0] ref_q [N];
    logic [CNTW-1:0] ref_d [N];
`else
    logic unused_refrac;
    assign unused_refrac = (REFRAC > 0);
`endif

    // Pairwise comparators, reused for every level: entry 2i vs 2i+1 lands in entry i.
    for (genvar i = 0; i < H; i++) begin : g_node
        li_cmp_node #(.W(W), .IDXW(IDXW)) u_node (
            .a_valid (vld_q[2*i]),
            .a_value (val_q[2*i]),
            .a_index (idx_q[2*i]),
            .b_valid (vld_q[2*i+1]),
            .b_value (val_q[2*i+1]),
            .b_index (idx_q[2*i+1]),
            .y_valid (nxt_vld[i]),
            .y_value (nxt_val[i]),
            .y_index (nxt_idx[i])
        );
    end

    assign root_spk = vld_q[0] && (val_q[0] > thr_q);

    // Next-state logic: snapshot on accept, halve the tree each REDUCE cycle, then decide.
    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        thr_d    = thr_q;
        vld_d    = vld_q;
        val_d    = val_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        won_d    = won_q;
        widx_d   = widx_q;
        spiked_d = spiked_q;
        first_d  = first_q;
        armed_d  = armed_q;
`ifdef LI_REFRACTORY_EN
        ref_d    = ref_q;
`endif
        if (valid_q) begin
            won_d    = '0;
            spiked_d = 1'b0;
            first_d  = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_li) begin
                    for (int k = 0; k < N; k++) begin
`ifdef LI_REFRACTORY_EN
                        vld_d[k] = (ref_q[k] == '0);
                        if (ref_q[k] != '0) begin
                            ref_d[k] = ref_q[k] - CNTW'(1);
                        end
`else
                        vld_d[k] = 1'b1;
`endif
                        val_d[k] = potentials[k*W +: W];
                        idx_d[k] = IDXW'(k);
                    end
                    for (int k = N; k < P; k++) begin
                        vld_d[k] = 1'b0;
                        val_d[k] = '0;
                        idx_d[k] = IDXW'(k);
                    end
                    thr_d   = threshold;
                    lvl_d   = '0;
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                for (int i = 0; i < H; i++) begin
                    vld_d[i] = nxt_vld[i];
                    val_d[i] = nxt_val[i];
                    idx_d[i] = nxt_idx[i];
                end
                for (int i = H; i < P; i++) begin
                    vld_d[i] = 1'b0;
                end
                lvl_d = lvl_q + LVLW'(1);
                if (lvl_q == LVLW'(S - 1)) begin
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                valid_d  = 1'b1;
                spiked_d = root_spk;
                won_d    = root_spk ? (ONE_HOT_LSB << idx_q[0]) : '0;
                widx_d   = vld_q[0] ? idx_q[0] : '0;
                first_d  = root_spk && armed_q;
                if (root_spk) begin
                    armed_d = 1'b0;
                end
`ifdef LI_REFRACTORY_EN
                for (int k = 0; k < N; k++) begin
                    if (root_spk && (idx_q[0] == IDXW'(k))) begin
                        ref_d[k] = CNTW'(REFRAC);
                    end
                end
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear_first) begin
            armed_d = 1'b1;
        end
    end

    // State, snapshot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lvl_q    <= '0;
            thr_q    <= '0;
            for (int k = 0; k < P; k++) begin
                vld_q[k] <= 1'b0;
                val_q[k] <= '0;
                idx_q[k] <= '0;
            end
            valid_q  <= 1'b0;
            won_q    <= '0;
            widx_q   <= '0;
            spiked_q <= 1'b0;
            first_q  <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            thr_q    <= thr_d;
            vld_q    <= vld_d;
            val_q    <= val_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            won_q    <= won_d;
            widx_q   <= widx_d;
            spiked_q <= spiked_d;
            first_q  <= first_d;
            armed_q  <= armed_d;
        end
    end

`ifdef LI_REFRACTORY_EN
    // Per-neuron refractory counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                ref_q[k] <= '0;
            end
        end else begin
            ref_q <= ref_d;
        end
    end
`endif

    assign busy        = (state_q != ST_IDLE);
    assign valid_li    = valid_q;
    assign won_lost    = won_q;
    assign winner_idx  = widx_q;
    assign spiked      = spiked_q;
    assign first_spike = first_q;

endmodule

// File: tb/tb_li_wta.sv
// tb/tb_li_wta.sv - self-checking bench for li_wta (N=16 and N=5 instances, LI_REFRACTORY_EN aware)
module tb_li_wta;

    localparam int W = 24;
    localparam int RF = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            a_start, a_clr, a_busy, a_valid, a_spk, a_first;
    logic [16*W-1:0] a_pot;
    logic [W-1:0]    a_thr;
    logic [15:0]     a_won;
    logic [3:0]      a_idx;

    logic            b_start, b_clr, b_busy, b_valid, b_spk, b_first;
    logic [5*W-1:0]  b_pot;
    logic [W-1:0]    b_thr;
    logic [4:0]      b_won;
    logic [2:0]      b_idx;

    li_wta #(.N(16), .W(W), .REFRAC(RF)) dut_a (
        .clk(clk), .rst(rst), .start_li(a_start), .potentials(a_pot), .threshold(a_thr),
        .clear_first(a_clr), .busy(a_busy), .valid_li(a_valid), .won_lost(a_won),
        .winner_idx(a_idx), .spiked(a_spk), .first_spike(a_first)
    );

    li_wta #(.N(5), .W(W), .REFRAC(RF)) dut_b (
        .clk(clk), .rst(rst), .start_li(b_start), .potentials(b_pot), .threshold(b_thr),
        .clear_first(b_clr), .busy(b_busy), .valid_li(b_valid), .won_lost(b_won),
        .winner_idx(b_idx), .spiked(b_spk), .first_spike(b_first)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit armed [2];
    int refc [2][16];
    logic [W-1:0] pv [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            armed[d] = 1'b1;
            for (int k = 0; k < 16; k++) refc[d][k] = 0;
        end
    endtask

    task automatic fill(input logic [W-1:0] v);
        for (int k = 0; k < 16; k++) pv[k] = v;
    endtask

    // One decision on instance `which` (0: N=16, 1: N=5), checked against the reference model.
    task automatic run(input int which, input logic [W-1:0] thr, input bit clr);
        int n, lat, best, idx_e, cyc;
        bit vk, spk, first_e, got;
        logic [15:0] won_e;
        logic o_valid, o_busy, o_spk, o_first;
        logic [15:0] o_won;
        logic [3:0] o_idx;
        n   = which ? 5 : 16;
        lat = which ? 5 : 6;
        best = -1;
        for (int k = 0; k < n; k++) begin
            vk = 1'b1;
`ifdef LI_REFRACTORY_EN
            vk = (refc[which][k] == 0);
            if (refc[which][k] > 0) refc[which][k]--;
`endif
            if (vk && (best < 0 || pv[k] > pv[best])) best = k;
        end
        spk     = (best >= 0) && (pv[best] > thr);
        idx_e   = (best < 0) ? 0 : best;
        won_e   = spk ? (16'd1 << idx_e) : 16'd0;
        first_e = spk && armed[which];
        if (spk) begin
            armed[which] = 1'b0;
`ifdef LI_REFRACTORY_EN
            refc[which][best] = RF;
`endif
        end
        if (clr) armed[which] = 1'b1;

        for (int k = 0; k < 16; k++) a_pot[k*W +: W] = pv[k];
        for (int k = 0; k < 5; k++)  b_pot[k*W +: W] = pv[k];
        if (which != 0) begin b_thr = thr; b_start = 1'b1; end
        else            begin a_thr = thr; a_start = 1'b1; end

        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            a_start = 1'b0;
            b_start = 1'b0;
            o_valid = which ? b_valid : a_valid;
            o_busy  = which ? b_busy  : a_busy;
            o_spk   = which ? b_spk   : a_spk;
            o_first = which ? b_first : a_first;
            o_won   = which ? {11'd0, b_won} : a_won;
            o_idx   = which ? {1'b0, b_idx}  : a_idx;
            if (o_valid) begin
                got = 1'b1;
                chk("latency", cyc, lat);
                chk("busy_at_valid", o_busy, 0);
                chk("won_lost", o_won, won_e);
                chk("winner_idx", o_idx, idx_e);
                chk("spiked", o_spk, spk);
                chk("first_spike", o_first, first_e);
                if (which != 0) b_clr = clr; else a_clr = clr;
                @(negedge clk);
                a_clr = 1'b0;
                b_clr = 1'b0;
                o_spk = which ? b_spk : a_spk;
                o_won = which ? {11'd0, b_won} : a_won;
                o_idx = which ? {1'b0, b_idx}  : a_idx;
                chk("won_cleared", o_won, 0);
                chk("spiked_cleared", o_spk, 0);
                chk("idx_held", o_idx, idx_e);
            end else begin
                chk("busy_in_flight", o_busy, 1);
            end
        end
        if (!got) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        a_start = 0; a_clr = 0; a_pot = '0; a_thr = '0;
        b_start = 0; b_clr = 0; b_pot = '0; b_thr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_won", a_won, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_spiked", a_spk, 0);
        chk("rst_first", a_first, 0);
        chk("rst_b_valid", b_valid, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Directed: clear winner, sub-threshold, first-spike arming, tie, zero/zero, all-equal.
        fill(24'd10); pv[5] = 24'd200; run(0, 24'd90, 0);
        pv[5] = 24'd90;                run(0, 24'd90, 0);
        fill(24'd10); pv[9] = 24'd500; run(0, 24'd90, 0);
        run(0, 24'd90, 1);
        run(0, 24'd90, 0);
        fill(24'd10); pv[3] = 24'd300; pv[11] = 24'd300; run(0, 24'd90, 0);
        fill(24'd0);  run(0, 24'd0, 0);
        fill(24'd77); run(0, 24'd5, 0);
        fill(24'd10); pv[4] = 24'd999; run(1, 24'd90, 0);
        fill(24'd42); run(1, 24'd1, 0);
        fill(24'd10); pv[5] = 24'd800; pv[2] = 24'd400;
        for (int d = 0; d < 4; d++) run(0, 24'd90, 0);

        // Randomized decisions on both instances.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 16; k++)
                pv[k] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 6)) : W'($urandom);
            run(r % 2, ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 8)) : W'($urandom),
                ($urandom_range(0, 3) == 0));
        end

        // start_li held high: one valid per S+2 cycles, busy in between.
        fill(24'd1); pv[7] = 24'd50;
        for (int k = 0; k < 16; k++) a_pot[k*W +: W] = pv[k];
        a_thr = 24'd1000;
        a_start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 18) a_start = 1'b0;
            chk("cont_valid", a_valid, (c % 6) == 0);
            chk("cont_busy", a_busy, (c % 6) != 0);
        end
        @(negedge clk);
        chk("cont_idx_held", a_idx, 7);

        // Reset two cycles into a decision aborts it.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", a_busy, 0);
        chk("abort_idx", a_idx, 0);
        chk("abort_won", a_won, 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        model_reset();
        fill(24'd10); pv[12] = 24'd600; run(0, 24'd90, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
